// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared funct3 codes, FSM state and access-size/strobe helpers for mem_stage
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Unsigned variants only exist for loads; any other code falls back to a word access.
  function automatic size_t access_size(input logic [2:0] funct3, input logic is_store);
    case (funct3)
      F3_B:    return SZ_B;
      F3_H:    return SZ_H;
      F3_BU:   return is_store ? SZ_W : SZ_B;
      F3_HU:   return is_store ? SZ_W : SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] funct3, input logic [1:0] off);
    case (access_size(funct3, 1'b1))
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/half of a read word and sign/zero extends it
module load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);
  import mem_pkg::*;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sext;

  always_comb begin
    lane_b = mem_rdata[{off, 3'b000} +: 8];
    lane_h = mem_rdata[{off[1], 4'b0000} +: 16];
    sext   = ~funct3[2];
    case (access_size(funct3, 1'b0))
      SZ_B:    data = {{(XLEN-8){sext & lane_b[7]}}, lane_b};
      SZ_H:    data = {{(XLEN-16){sext & lane_h[15]}}, lane_h};
      default: data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: req/ack bus access, bus timeout, registered writeback
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses retire with err_o instead of issuing.
module mem_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_rd,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_reg_write,
  output logic            stall_o,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_reg_write,
  output logic            err_o
);
  import mem_pkg::*;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t          state, state_n;
  logic [15:0]     tmo_cnt;
  logic [4:0]      rd_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            rw_q;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wdata_n;
  logic            is_mem, is_store, misalign;
  logic            accept, issue, finish_ack, finish_tmo;

  assign is_mem   = ex_mem_read | ex_mem_write;
  assign is_store = ex_mem_write & ~ex_mem_read;
  assign stall_o  = (state != IDLE);

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    case (access_size(ex_funct3, is_store))
      SZ_H:    misalign = ex_alu_out[0];
      SZ_W:    misalign = |ex_alu_out[1:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    case (access_size(ex_funct3, 1'b1))
      SZ_B:    wdata_n = {(XLEN/8){ex_store_data[7:0]}};
      SZ_H:    wdata_n = {(XLEN/16){ex_store_data[15:0]}};
      default: wdata_n = ex_store_data;
    endcase
  end

  // Ack takes priority over the timeout when both land in the same cycle.
  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    issue      = 1'b0;
    finish_ack = 1'b0;
    finish_tmo = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          accept = 1'b1;
          if (is_mem && !misalign) begin
            issue   = 1'b1;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          finish_ack = 1'b1;
          state_n    = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          finish_tmo = 1'b1;
          state_n    = IDLE;
        end
      end
    endcase
  end

  load_align #(.XLEN(XLEN)) u_align (
    .mem_rdata (mem_rdata),
    .off       (off_q),
    .funct3    (f3_q),
    .data      (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      rd_q         <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      rw_q         <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_reg_write <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state    <= state_n;
      wb_valid <= 1'b0;
      err_o    <= 1'b0;
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= is_store;
        mem_addr  <= {ex_alu_out[XLEN-1:2], 2'b00};
        mem_wstrb <= is_store ? store_strobe(ex_funct3, ex_alu_out[1:0]) : 4'b0000;
        mem_wdata <= is_store ? wdata_n : '0;
        rd_q      <= ex_rd;
        f3_q      <= ex_funct3;
        off_q     <= ex_alu_out[1:0];
        rw_q      <= ex_reg_write & (ex_rd != 5'd0);
        tmo_cnt   <= '0;
      end else if (accept) begin
        wb_valid     <= 1'b1;
        wb_rd        <= ex_rd;
        wb_data      <= is_mem ? '0 : ex_alu_out;
        wb_reg_write <= ~is_mem & ex_reg_write & (ex_rd != 5'd0);
        err_o        <= is_mem;
      end
      if (finish_ack) begin
        mem_req      <= 1'b0;
        wb_valid     <= 1'b1;
        wb_rd        <= rd_q;
        wb_data      <= mem_we ? '0 : load_data;
        wb_reg_write <= ~mem_we & rw_q;
      end else if (finish_tmo) begin
        mem_req      <= 1'b0;
        wb_valid     <= 1'b1;
        wb_rd        <= rd_q;
        wb_data      <= '0;
        wb_reg_write <= 1'b0;
        err_o        <= 1'b1;
      end else if (state == BUSY) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized scoreboard bench for mem_stage with a bus responder model
module tb_mem_stage;
  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu_out = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        stall_o, mem_req, mem_we, wb_valid, wb_reg_write, err_o;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  wb_rd;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .stall_o(stall_o), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
    .err_o(err_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
    logic        err;
    logic        chk_data;
    int          cyc;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   manual  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: every writeback or error beat must match the oldest expectation.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (wb_valid || err_o) begin
        if (wb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_wb: got wb_valid=%b err_o=%b expected no beat", wb_valid, err_o);
        end else begin
          e = wb_q.pop_front();
          chk("wb_valid", 32'(wb_valid), 32'd1);
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
          chk("err_o", 32'(err_o), 32'(e.err));
          chk("wb_latency", 32'(cyc), 32'(e.cyc));
          if (e.chk_data) chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  // Bus responder: checks each request against the model and acks after its chosen delay.
  initial begin
    bus_t cur;
    bit   act = 1'b0;
    int   cnt = 0;
    forever begin
      @(negedge clk);
      if (!manual) begin
        if (act && !mem_req) begin
          act     = 1'b0;
          mem_ack = 1'b0;
        end
        if (mem_req && !act) begin
          if (bus_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_req: got mem_req=1 addr %h expected no request", mem_addr);
          end else begin
            cur = bus_q.pop_front();
            act = 1'b1;
            cnt = 0;
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_we", 32'(mem_we), 32'(cur.we));
            if (cur.we) begin
              chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
              chk("mem_wdata", mem_wdata, cur.wdata);
            end
          end
        end
        if (act) begin
          cnt++;
          chk("stall_busy", 32'(stall_o), 32'd1);
          mem_ack   = (cnt == cur.delay);
          mem_rdata = mem_ack ? cur.rdata : $urandom;
        end
      end
    end
  end

  task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                       input logic rw, input int delay, input logic [31:0] rdata);
    wb_t  e;
    bus_t b;
    int   w = 0;
    int   sz;
    int   v;
    logic [1:0] off;
    logic is_store, mis, sgn;
    @(negedge clk);
    while (stall_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (stall_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_wait: got stall_o=1 expected 0");
      return;
    end
    off      = addr[1:0];
    is_store = wr_en && !rd_en;
    sgn      = (f3[2] == 1'b0);
    if (is_store) sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else          sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
    mis = (sz == 2 && off[0]) || (sz == 4 && off != 2'd0);
`else
    mis = 1'b0;
`endif
    e.rd = rd; e.data = 32'd0; e.rw = 1'b0; e.err = 1'b0; e.chk_data = 1'b0; e.cyc = cyc + 1;
    if (!(rd_en || wr_en)) begin
      e.data = addr; e.chk_data = 1'b1; e.rw = rw && (rd != 5'd0);
    end else if (mis) begin
      e.err = 1'b1;
    end else begin
      b.addr  = addr & 32'hFFFF_FFFC;
      b.we    = is_store;
      b.delay = delay;
      b.rdata = rdata;
      b.wstrb = (sz == 1) ? 4'(1 << off) : (sz == 2) ? 4'(3 << off) : 4'hF;
      b.wdata = (sz == 1) ? {4{sdata[7:0]}} : (sz == 2) ? {2{sdata[15:0]}} : sdata;
      bus_q.push_back(b);
      if (delay > TO) begin
        e.err = 1'b1;
        e.cyc = cyc + 1 + TO;
      end else begin
        e.cyc = cyc + 1 + delay;
        if (!is_store) begin
          if (sz == 1) begin
            v = int'((rdata >> (8 * off)) & 32'hFF);
            if (sgn && v >= 128) v -= 256;
          end else if (sz == 2) begin
            v = int'((rdata >> (16 * off[1])) & 32'hFFFF);
            if (sgn && v >= 32768) v -= 65536;
          end else begin
            v = int'(rdata);
          end
          e.data = 32'(v); e.chk_data = 1'b1; e.rw = rw && (rd != 5'd0);
        end
      end
    end
    wb_q.push_back(e);
    ex_valid = 1'b1; ex_alu_out = addr; ex_store_data = sdata; ex_rd = rd; ex_funct3 = f3;
    ex_mem_read = rd_en; ex_mem_write = wr_en; ex_reg_write = rw;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((stall_o || wb_q.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_idle", 32'(stall_o || wb_q.size() != 0), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got %0d cycles expected finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int op;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst = 1'b0;

    issue(0, 0, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 1, 0, 32'd0);
    #1 chk("add_stall", 32'(stall_o), 32'd0);

    issue(0, 1, 3'd0, 32'h0000_0102, 32'h0000_00AB, 5'd3, 0, 3, 32'd0);
    sc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall_o) break;
      sc++;
    end
    chk("sb_stall_cycles", 32'(sc), 32'd3);

    issue(1, 0, 3'd0, 32'h0000_0203, 32'd0, 5'd7, 1, 1, 32'h80FF_0000);
    issue(1, 0, 3'd4, 32'h0000_0203, 32'd0, 5'd7, 1, 1, 32'h80FF_0000);
    issue(1, 0, 3'd2, 32'h0000_0040, 32'd0, 5'd9, 1, TO + 1, 32'd0);
    issue(1, 0, 3'd2, 32'h0000_0040, 32'd0, 5'd9, 1, TO, 32'hCAFE_F00D);
    issue(1, 0, 3'd2, 32'h0000_0301, 32'd0, 5'd10, 1, 2, 32'h1357_9BDF);
    issue(1, 0, 3'd1, 32'h0000_0502, 32'd0, 5'd0, 1, 1, 32'h8001_7FFF);
    issue(0, 0, 3'd0, 32'h0000_0077, 32'd0, 5'd0, 1, 0, 32'd0);

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 2);
      issue(op == 1, op == 2, 3'($urandom_range(0, 7)), $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(1, TO + 1), $urandom);
    end

    wait_idle();
    manual = 1'b1;
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'd2;
    ex_alu_out = 32'h0000_0400; ex_rd = 5'd4; ex_reg_write = 1'b1;
    @(posedge clk);
    #1 ex_valid = 1'b0;
    @(negedge clk);
    chk("rst_test_req_up", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("busy_rst_mem_req", 32'(mem_req), 32'd0);
    chk("busy_rst_stall", 32'(stall_o), 32'd0);
    chk("busy_rst_addr", mem_addr, 32'd0);
    chk("busy_rst_wb_valid", 32'(wb_valid), 32'd0);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("late_ack_mem_req", 32'(mem_req), 32'd0);
    chk("late_ack_stall", 32'(stall_o), 32'd0);
    mem_ack = 1'b0;
    @(negedge clk);
    manual = 1'b0;

    issue(1, 0, 3'd5, 32'h0000_0602, 32'd0, 5'd12, 1, 2, 32'hBEEF_0000);
    wait_idle();
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
